// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 program loader: FSM states,
// default geometry and RAM read/write strobe encodings.
package sap1_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SETUP,
        S_WRITE,
        S_READ,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int DEPTH_DEF = 16;
    localparam int AW_DEF    = 4;

    // Polarity of ram_leitura_escrita
    localparam logic STROBE_READ  = 1'b1;
    localparam logic STROBE_WRITE = 1'b0;

endpackage

// File: rtl/carregador_ram.sv
// Program loader: accepts DEPTH bytes from a valid/ready source, writes
// them into the SAP-1 RAM with a SETUP/WRITE strobe sequence, then reads
// the whole RAM back and flags a mismatch between the two byte sums.
module carregador_ram
    import sap1_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_data_in,
    output logic          ram_run_prog,
    output logic          ram_ce,
    output logic          ram_leitura_escrita,
    input  logic [7:0]    ram_data_out,
    output logic          busy,
    output logic          done,
    output logic          erro,
    output logic [7:0]    checksum
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    rsum_q, rsum_d;
    logic          erro_q, erro_d;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            sum_q   <= '0;
            rsum_q  <= '0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
            rsum_q  <= rsum_d;
            erro_q  <= erro_d;
        end
    end

    // Next-state, datapath updates and RAM control decoded from state
    always_comb begin
        state_d             = state_q;
        addr_d              = addr_q;
        data_d              = data_q;
        sum_d               = sum_q;
        rsum_d              = rsum_q;
        erro_d              = erro_q;
        byte_ready          = 1'b0;
        ram_ce              = 1'b0;
        ram_leitura_escrita = STROBE_READ;
        ram_run_prog        = 1'b0;
        busy                = 1'b1;
        done                = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                done = (state_q == S_DONE);
                if (start) begin
                    addr_d  = '0;
                    sum_d   = '0;
                    rsum_d  = '0;
                    erro_d  = 1'b0;
                    state_d = S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    data_d  = byte_in;
                    sum_d   = sum_q + byte_in;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                ram_run_prog = 1'b1;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                ram_ce              = 1'b1;
                ram_leitura_escrita = STROBE_WRITE;
                ram_run_prog        = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_READ;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = S_WAIT_BYTE;
                end
            end
            S_READ: begin
                ram_ce = 1'b1;
                rsum_d = rsum_q + ram_data_out;
                if (addr_q == LAST_ADDR) begin
                    state_d = S_CHECK;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_CHECK: begin
                erro_d  = (rsum_q != sum_q);
                state_d = S_DONE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign ram_addr    = addr_q;
    assign ram_data_in = data_q;
    assign erro        = erro_q;
    assign checksum    = sum_q;

endmodule

// File: tb/tb_carregador_ram.sv
// Self-checking bench for carregador_ram: behavioural RAM, write
// scoreboard and per-session result scoreboard.
module tb_carregador_ram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [3:0] ram_addr;
    logic [7:0] ram_data_in;
    logic       ram_run_prog;
    logic       ram_ce;
    logic       ram_leitura_escrita;
    wire  [7:0] ram_data_out;
    logic       busy;
    logic       done;
    logic       erro;
    logic [7:0] checksum;

    carregador_ram #(.DEPTH(16), .AW(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .byte_in             (byte_in),
        .byte_valid          (byte_valid),
        .byte_ready          (byte_ready),
        .ram_addr            (ram_addr),
        .ram_data_in         (ram_data_in),
        .ram_run_prog        (ram_run_prog),
        .ram_ce              (ram_ce),
        .ram_leitura_escrita (ram_leitura_escrita),
        .ram_data_out        (ram_data_out),
        .busy                (busy),
        .done                (done),
        .erro                (erro),
        .checksum            (checksum)
    );

    always #5 clk = ~clk;

    // Behavioural RAM; corrupt_en adds 1 to the word read at address 5
    logic [7:0] mem [16];
    logic       clr;
    logic       corrupt_en;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hAA;
        end else if (ram_ce && !ram_leitura_escrita) begin
            mem[ram_addr] <= ram_data_in;
        end
    end

    assign ram_data_out = (ram_ce && ram_leitura_escrita)
                        ? mem[ram_addr] + ((corrupt_en && ram_addr == 4'd5) ? 8'd1 : 8'd0)
                        : 8'hzz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    typedef struct {
        logic [7:0] csum;
        logic       err;
        int         done_edge;
    } res_t;

    wr_t        wq[$];
    res_t       rq[$];
    logic [7:0] pat [16];

    // One load session. Edges are numbered with the start-sampling edge as 1;
    // cycle n is the cycle following the n-th edge after the start edge.
    task automatic run_session(input int period, input bit corrupt, input bit poke,
                               input int exp_done);
        int         n = 0;
        logic [7:0] esum = 8'h00;
        bit         got_done = 0;
        bit         in_read = 0;
        bit         poked = 0;
        bit         acc;
        int         done_edge = -1;
        logic [3:0] s_addr = 4'h0;
        logic [7:0] s_data = 8'h00;
        wr_t        w;
        res_t       r;

        for (int i = 0; i < 16; i++) esum = esum + pat[i];
        rq.push_back('{esum, corrupt, exp_done});

        clr = 1'b1;
        @(posedge clk); #1;
        clr        = 1'b0;
        corrupt_en = corrupt;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        check_eq("sum_cleared", checksum, 0);
        check_eq("erro_cleared", erro, 0);

        for (int cyc = 1; cyc <= 400 && !got_done; cyc++) begin
            byte_valid = (n < 16) && (period == 1 || (cyc % period) == 0);
            byte_in    = byte_valid ? pat[n] : 8'h5A;
            start      = poke && in_read && !poked;
            if (start) poked = 1;
            @(negedge clk);
            acc = byte_ready && byte_valid;
            if (acc) wq.push_back('{n, pat[n], (period == 1) ? 3 * n + 3 : -1});
            if (ram_run_prog && !ram_ce) begin
                s_addr = ram_addr;
                s_data = ram_data_in;
            end
            if (ram_ce && !ram_leitura_escrita) begin
                check_eq("ready_in_write", byte_ready, 0);
                check_eq("wr_pending", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    check_eq("wr_addr", ram_addr, w.addr);
                    check_eq("wr_data", ram_data_in, w.data);
                    check_eq("wr_addr_stable", ram_addr, s_addr);
                    check_eq("wr_data_stable", ram_data_in, s_data);
                    if (w.cyc >= 0) check_eq("wr_cycle", cyc, w.cyc);
                end
            end
            if (ram_ce && ram_leitura_escrita) in_read = 1;
            @(posedge clk);
            if (acc) n++;
            #1;
            if (done) begin
                got_done  = 1;
                done_edge = cyc + 1;
            end
        end
        start      = 1'b0;
        byte_valid = 1'b0;

        r = rq.pop_front();
        check_eq("done_edge", done_edge, r.done_edge);
        check_eq("checksum", checksum, r.csum);
        check_eq("erro", erro, r.err);
        check_eq("busy_at_done", busy, 0);
        check_eq("bytes_taken", n, 16);
        check_eq("wr_queue_empty", wq.size(), 0);
        for (int i = 0; i < 16; i++) check_eq("ram_word", mem[i], pat[i]);
        corrupt_en = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ce"}, ram_ce, 0);
        check_eq({tag, "_rw"}, ram_leitura_escrita, 1);
        check_eq({tag, "_prog"}, ram_run_prog, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_ready"}, byte_ready, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_erro"}, erro, 0);
        check_eq({tag, "_sum"}, checksum, 0);
        check_eq({tag, "_addr"}, ram_addr, 0);
        check_eq({tag, "_data"}, ram_data_in, 0);
    endtask

    initial begin
        bit found;

        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        clr        = 1'b0;
        corrupt_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Incrementing pattern, byte_valid held high
        for (int i = 0; i < 16; i++) pat[i] = 8'(i);
        run_session(1, 0, 0, 66);

        // Source offers a byte one cycle in three
        run_session(3, 0, 0, 68);

        // All-ones bytes: sum wraps to 0xF0
        for (int i = 0; i < 16; i++) pat[i] = 8'hFF;
        run_session(1, 0, 0, 66);

        // Readback corrupted at address 5
        for (int i = 0; i < 16; i++) pat[i] = 8'(i);
        run_session(1, 1, 0, 66);

        // Reset asserted while byte 7 is being written
        start = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h33;
        found      = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (ram_ce && !ram_leitura_escrita && ram_addr == 4'd7) begin
                found = 1;
                rst_n = 1'b0;
            end
            @(posedge clk); #1;
        end
        check_eq("rst_reached_w7", found, 1);
        byte_valid = 1'b0;
        check_idle_outputs("rst_in_write");
        rst_n = 1'b1;
        run_session(1, 0, 0, 66);

        // start pulsed during readback must be ignored
        for (int i = 0; i < 16; i++) pat[i] = 8'(8'h30 + 8'(i * 7));
        run_session(1, 0, 1, 66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
